// File: rtl/timer8254_pkg.sv
// Shared constants and helpers for the 8254 control-word path.
package timer8254_pkg;

    localparam logic [1:0] ADDR_CW     = 2'b11;
    localparam logic [1:0] SC_READBACK = 2'b11;
    localparam logic [1:0] RW_LATCH    = 2'b00;
    localparam logic [1:0] RB_IDLE     = 2'b11;

    localparam int unsigned SC_MSB   = 7;
    localparam int unsigned SC_LSB   = 6;
    localparam int unsigned RW_MSB   = 5;
    localparam int unsigned RW_LSB   = 4;
    localparam int unsigned MODE_MSB = 3;
    localparam int unsigned MODE_LSB = 1;
    localparam int unsigned BCD_BIT  = 0;

    // Modes 6 and 7 are aliases of 2 and 3; store the canonical form.
    function automatic logic [2:0] norm_mode(input logic [2:0] mode);
        logic [2:0] m;
        m = mode;
        if (m[1]) m[2] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/rb_pending.sv
// Per-counter pending readback register {COUNT_, STATUS_}, active low.
module rb_pending
    import timer8254_pkg::*;
(
    input  logic       clk,
    input  logic       reset_,
    input  logic       ack,
    input  logic       clear,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_mask,
    output logic [1:0] rb
);

    logic [1:0] rb_q;
    logic [1:0] rb_d;
    logic [1:0] base;

    // Ack clears first so a same-cycle command still lands on an idle register.
    always_comb begin
        base = ack ? RB_IDLE : rb_q;
        rb_d = base;
        if (clear) begin
            rb_d = RB_IDLE;
        end else if (cmd_valid) begin
            rb_d = base & cmd_mask;
        end
    end

    // Pending state register.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            rb_q <= RB_IDLE;
        end else begin
            rb_q <= rb_d;
        end
    end

    assign rb = rb_q;

endmodule

// File: rtl/cwr_dispatcher.sv
// Control-word decode, CWR distribution, readback requests and read mux.
module cwr_dispatcher
    import timer8254_pkg::*;
#(
    parameter int unsigned NUM_COUNTERS = 3
) (
    input  logic       clk,
    input  logic       reset_,
    input  logic [7:0] databus,
    input  logic [1:0] addrbus,
    input  logic       RWbus,
    input  logic       bus_strobe,
    output logic [5:0] CWR0,
    output logic [5:0] CWR1,
    output logic [5:0] CWR2,
    output logic [2:0] cw_load,
    output logic [1:0] readback0,
    output logic [1:0] readback1,
    output logic [1:0] readback2,
    input  logic [2:0] rb_ack,
    output logic [2:0] cs,
    input  logic [7:0] cnt_dout0,
    input  logic [7:0] cnt_dout1,
    input  logic [7:0] cnt_dout2,
    output logic [7:0] dout
);

    logic                    wr_cw;
    logic [1:0]              sc;
    logic [1:0]              rw;
    logic [NUM_COUNTERS-1:0] cw_wr;
    logic [NUM_COUNTERS-1:0] cmd_valid;
    logic [1:0]              cmd_mask [NUM_COUNTERS];
    logic [1:0]              rb       [NUM_COUNTERS];
    logic [5:0]              cwr_q    [NUM_COUNTERS];
    logic [5:0]              new_cwr;
    logic [2:0]              cs_d;
    logic [7:0]              rd_data;
    logic [2:0]              cw_load_q;
    logic [2:0]              cs_q;
    logic [7:0]              dout_q;

    assign wr_cw   = bus_strobe && !RWbus && (addrbus == ADDR_CW);
    assign sc      = databus[SC_MSB:SC_LSB];
    assign rw      = databus[RW_MSB:RW_LSB];
    assign new_cwr = {rw, norm_mode(databus[MODE_MSB:MODE_LSB]), databus[BCD_BIT]};

    // Per-counter command decode: CW write, counter latch or read-back.
    always_comb begin
        cw_wr     = '0;
        cmd_valid = '0;
        for (int unsigned n = 0; n < NUM_COUNTERS; n++) begin
            cmd_mask[n] = RB_IDLE;
            if (wr_cw && (32'(sc) == n)) begin
                if (rw != RW_LATCH) begin
                    cw_wr[n] = 1'b1;
                end else begin
                    cmd_valid[n] = 1'b1;
                    cmd_mask[n]  = 2'b01;
                end
            end else if (wr_cw && (sc == SC_READBACK) && !databus[0] && databus[1 + n]) begin
                cmd_valid[n] = 1'b1;
                cmd_mask[n]  = rw;
            end
        end
    end

    for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_rb
        rb_pending u_rb_pending (
            .clk       (clk),
            .reset_    (reset_),
            .ack       (rb_ack[g]),
            .clear     (cw_wr[g]),
            .cmd_valid (cmd_valid[g]),
            .cmd_mask  (cmd_mask[g]),
            .rb        (rb[g])
        );
    end

    // Data-access select and read-data mux.
    always_comb begin
        cs_d    = '0;
        rd_data = 8'h00;
        unique case (addrbus)
            2'b00: begin cs_d = 3'b001; rd_data = cnt_dout0; end
            2'b01: begin cs_d = 3'b010; rd_data = cnt_dout1; end
            2'b10: begin cs_d = 3'b100; rd_data = cnt_dout2; end
            default: begin cs_d = 3'b000; rd_data = 8'h00; end
        endcase
        if (!bus_strobe) cs_d = '0;
    end

    // CWR registers, one-cycle pulses and held read data.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            for (int unsigned n = 0; n < NUM_COUNTERS; n++) cwr_q[n] <= '0;
            cw_load_q <= '0;
            cs_q      <= '0;
            dout_q    <= 8'h00;
        end else begin
            for (int unsigned n = 0; n < NUM_COUNTERS; n++) begin
                if (cw_wr[n]) cwr_q[n] <= new_cwr;
            end
            cw_load_q <= cw_wr;
            cs_q      <= cs_d;
            if (bus_strobe && RWbus) dout_q <= rd_data;
        end
    end

    assign CWR0      = cwr_q[0];
    assign CWR1      = cwr_q[1];
    assign CWR2      = cwr_q[2];
    assign readback0 = rb[0];
    assign readback1 = rb[1];
    assign readback2 = rb[2];
    assign cw_load   = cw_load_q;
    assign cs        = cs_q;
    assign dout      = dout_q;

endmodule

// File: tb/tb_cwr_dispatcher.sv
// Randomised and directed bench for cwr_dispatcher against a behavioural model.
module tb_cwr_dispatcher;

    logic       clk = 1'b0;
    logic       reset_ = 1'b0;
    logic [7:0] databus = 8'h00;
    logic [1:0] addrbus = 2'b00;
    logic       RWbus = 1'b0;
    logic       bus_strobe = 1'b0;
    logic [2:0] rb_ack = 3'b000;
    logic [7:0] cnt_dout0 = 8'h00, cnt_dout1 = 8'h00, cnt_dout2 = 8'h00;
    logic [5:0] CWR0, CWR1, CWR2;
    logic [2:0] cw_load, cs;
    logic [1:0] readback0, readback1, readback2;
    logic [7:0] dout;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    // Model state: what each output must show after the most recent edge.
    logic [5:0] m_cwr [3];
    logic [1:0] m_rb [3];
    logic [2:0] m_load, m_cs;
    logic [7:0] m_dout;

    cwr_dispatcher #(.NUM_COUNTERS(3)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .databus    (databus),
        .addrbus    (addrbus),
        .RWbus      (RWbus),
        .bus_strobe (bus_strobe),
        .CWR0       (CWR0),
        .CWR1       (CWR1),
        .CWR2       (CWR2),
        .cw_load    (cw_load),
        .readback0  (readback0),
        .readback1  (readback1),
        .readback2  (readback2),
        .rb_ack     (rb_ack),
        .cs         (cs),
        .cnt_dout0  (cnt_dout0),
        .cnt_dout1  (cnt_dout1),
        .cnt_dout2  (cnt_dout2),
        .dout       (dout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 3; n++) begin
            m_cwr[n] = 6'd0;
            m_rb[n]  = 2'b11;
        end
        m_load = 3'b000;
        m_cs   = 3'b000;
        m_dout = 8'h00;
    endtask

    // Drive one bus cycle, predict its effect, advance past the clock edge.
    task automatic cyc(input logic s, input logic rw, input logic [1:0] a,
                       input logic [7:0] d, input logic [2:0] ack);
        logic [5:0] c [3];
        logic [1:0] r [3];
        logic [2:0] ld, sel;
        logic [7:0] dv;
        int sc, mode;
        bus_strobe = s; RWbus = rw; addrbus = a; databus = d; rb_ack = ack;
        ld = 3'b000;
        sel = (s && a != 2'b11) ? 3'(1 << a) : 3'b000;
        dv = m_dout;
        if (s && rw) begin
            case (a)
                2'd0: dv = cnt_dout0;
                2'd1: dv = cnt_dout1;
                2'd2: dv = cnt_dout2;
                default: dv = 8'h00;
            endcase
        end
        sc = int'(d[7:6]);
        for (int n = 0; n < 3; n++) begin
            c[n] = m_cwr[n];
            r[n] = ack[n] ? 2'b11 : m_rb[n];
            if (s && !rw && a == 2'b11) begin
                if (sc == n) begin
                    if (d[5:4] != 2'b00) begin
                        mode = int'(d[3:1]);
                        if (mode >= 6) mode = mode - 4;
                        c[n] = {d[5:4], 3'(mode), d[0]};
                        ld[n] = 1'b1;
                        r[n] = 2'b11;
                    end else begin
                        r[n][1] = 1'b0;
                    end
                end else if (sc == 3 && !d[0] && d[1 + n]) begin
                    r[n] = r[n] & d[5:4];
                end
            end
        end
        @(posedge clk);
        if (reset_) begin
            for (int n = 0; n < 3; n++) begin
                m_cwr[n] = c[n];
                m_rb[n]  = r[n];
            end
            m_load = ld; m_cs = sel; m_dout = dv;
        end else begin
            model_reset();
        end
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
    endtask

    task automatic wr_cw(input logic [7:0] d);
        cyc(1'b1, 1'b0, 2'b11, d, 3'b000);
    endtask

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("CWR0", 8'(CWR0), 8'(m_cwr[0]));
            chk("CWR1", 8'(CWR1), 8'(m_cwr[1]));
            chk("CWR2", 8'(CWR2), 8'(m_cwr[2]));
            chk("cw_load", 8'(cw_load), 8'(m_load));
            chk("readback0", 8'(readback0), 8'(m_rb[0]));
            chk("readback1", 8'(readback1), 8'(m_rb[1]));
            chk("readback2", 8'(readback2), 8'(m_rb[2]));
            chk("cs", 8'(cs), 8'(m_cs));
            chk("dout", dout, m_dout);
        end
    end

    initial begin
        model_reset();
        check_en = 1'b1;
        repeat (2) idle();
        chk("reset_rb0", 8'(readback0), 8'h03);
        chk("reset_dout", dout, 8'h00);
        reset_ = 1'b1;
        idle();

        // Mode write to counter 0
        wr_cw(8'b00_11_011_0);
        chk("lit_cwr0", 8'(CWR0), 8'h36);
        chk("lit_load0", 8'(cw_load), 8'h01);
        chk("lit_cwr1", 8'(CWR1), 8'h00);
        idle();
        chk("lit_load_gone", 8'(cw_load), 8'h00);

        // Mode normalisation on counter 2
        wr_cw(8'b10_01_111_1);
        chk("lit_cwr2", 8'(CWR2), 8'h17);
        chk("lit_load2", 8'(cw_load), 8'h04);

        // Counter latch on counter 1, held until ack
        wr_cw(8'b01_00_0000);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("lit_latch_hold", 8'(readback1), 8'h01);
        end
        cyc(1'b0, 1'b0, 2'b00, 8'h00, 3'b010);
        chk("lit_ack1", 8'(readback1), 8'h03);

        // Read-back on counters 0 and 2
        wr_cw(8'b11_0_0_101_0);
        chk("lit_rb0", 8'(readback0), 8'h00);
        chk("lit_rb1", 8'(readback1), 8'h03);
        chk("lit_rb2", 8'(readback2), 8'h00);
        wr_cw(8'b11_1_0_001_0);
        chk("lit_rb0_keep", 8'(readback0), 8'h00);
        wr_cw(8'b11_0_0_111_1);
        chk("lit_reserved", 8'(readback2), 8'h00);

        // Ack colliding with a read-back command
        cyc(1'b1, 1'b0, 2'b11, 8'b11_1_0_001_0, 3'b001);
        chk("lit_collide", 8'(readback0), 8'h02);

        // Read mux
        cnt_dout1 = 8'd119;
        cyc(1'b1, 1'b1, 2'b01, 8'h00, 3'b000);
        chk("lit_dout", dout, 8'd119);
        chk("lit_cs", 8'(cs), 8'h02);
        idle();
        chk("lit_dout_hold", dout, 8'd119);
        cyc(1'b1, 1'b1, 2'b11, 8'h00, 3'b000);
        chk("lit_dout_cw", dout, 8'h00);

        // Reset while readbacks are pending
        wr_cw(8'b11_0_0_111_0);
        #2;
        reset_ = 1'b0;
        #1;
        chk("lit_async_rb0", 8'(readback0), 8'h03);
        chk("lit_async_rb2", 8'(readback2), 8'h03);
        chk("lit_async_cwr0", 8'(CWR0), 8'h00);
        model_reset();
        idle();
        reset_ = 1'b1;
        idle();

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] a;
            logic [2:0] ack;
            cnt_dout0 = 8'($urandom);
            cnt_dout1 = 8'($urandom);
            cnt_dout2 = 8'($urandom);
            a = ($urandom_range(0, 1) == 0) ? 2'b11 : 2'($urandom);
            ack = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), a,
                8'($urandom), ack);
        end

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cwr_dispatcher.md
# cwr_dispatcher

Control-word dispatcher for the 8254 timer: decodes bus writes to the control-word address (addrbus = 2'b11) and distributes the result to the three counter control blocks. It delivers per-counter CWR fields with a load pulse, converts counter-latch and read-back commands into held, active-low readback requests, and multiplexes counter read data onto a registered output. It sits between the external bus interface and the three per-counter control logic instances.

## Interface
- NUM_COUNTERS, 3: number of counters served; fixed by the 8254 architecture.
- clk  in  1  system clock; all state updates on rising edge.
- reset_  in  1  asynchronous, active-low reset.
- databus  in  8  write data from bus.
- addrbus  in  2  2'b00..2'b10 = counter 0..2; 2'b11 = control word.
- RWbus  in  1  0 = write, 1 = read.
- bus_strobe  in  1  one-cycle qualifier; an access happens only when high.
- CWR0, CWR1, CWR2  out  6  per-counter control word: [5:4] RW, [3:1] mode, [0] BCD.
- cw_load  out  3  one-cycle pulse per counter when its CWR is rewritten.
- readback0, readback1, readback2  out  2  [1] = COUNT_, [0] = STATUS_; active low, held until acknowledged.
- rb_ack  in  3  one-cycle acknowledge from counter n; clears its pending readback.
- cs  out  3  one-hot counter select, registered, for data accesses to addresses 0..2.
- cnt_dout0, cnt_dout1, cnt_dout2  in  8  counter output-latch read data.
- dout  out  8  registered read data.

## Operation
Decode applies on a write (bus_strobe = 1, RWbus = 0, addrbus = 2'b11). Fields are SC = databus[7:6] and RW = databus[5:4].

- **CW write** (SC = n < 3, RW ≠ 00):
  - CWRn <= databus[5:0], with the mode normalised: if mode[1] = 1, then mode[2] <= 0 (6→2, 7→3).
  - cw_load[n] pulses high.
  - Any pending readback of counter n is cleared to 2'b11.
- **Counter latch** (SC = n < 3, RW = 00):
  - readbackn[1] <= 0.
  - readbackn[0] is unchanged; CWRn is unchanged.
- **Read-back** (SC = 11, databus[0] = 0):
  - For each n with databus[1+n] = 1: readbackn <= readbackn & databus[5:4].
  - Both bits 1 means no-op.
- **Read-back with databus[0] = 1**: reserved; ignored entirely.
- **rb_ack[n]**: readbackn <= 2'b11.
- **Same-cycle ack and command for the same counter**: the ack clears first, then the command applies. The result equals the command bits.
- **Data access** (bus_strobe = 1, addrbus < 3): cs[addrbus] is high for one cycle. A write to addrbus < 3 changes no dispatcher state.
- **Read** (bus_strobe = 1, RWbus = 1):
  - dout <= cnt_doutN for addrbus = N.
  - dout <= 8'h00 for addrbus = 2'b11.
  - dout holds its value between reads.
- **Reset values:** CWR0–2 = 6'b000000; cw_load = 0; readback0–2 = 2'b11; cs = 0; dout = 8'h00.

## Timing
- All outputs are registered, with 1-cycle latency from the strobe edge to CWRn, cw_load, readbackn, cs and dout.
- cw_load is high exactly the cycle in which the new CWRn is first visible.
- A readback request stays asserted from one cycle after the command until one cycle after rb_ack; the minimum assertion is 1 cycle.
- Back-to-back strobes on consecutive cycles are each processed; there is no busy state.
- Asynchronous reset mid-operation:
  - Pending readbacks are dropped.
  - In-flight cw_load pulses are suppressed.
  - Counters see CWR = 0 until rewritten.
- The per-counter pending state is a 2-bit register, {COUNT_, STATUS_}:
  - 11 = idle.
  - 01 = count latch pending.
  - 10 = status pending.
  - 00 = both pending.
  - Transitions only by AND with a command, or by set-to-11 on ack, CW write or reset.

## Structure
- **Shared package** timer8254_pkg holds:
  - ADDR_CW = 2'b11, SC_READBACK = 2'b11, RW_LATCH = 2'b00.
  - Field positions SC_MSB/LSB, RW_MSB/LSB, MODE_MSB/LSB, BCD_BIT.
  - RB_IDLE = 2'b11.
  - A function normalising mode.
- **Sub-module:** rb_pending, one per counter (3 instances). It holds the 2-bit pending register and the ack-then-command priority.
- Top level contains the decode, the CWR registers, the cw_load/cs pulses and the read mux.

## Test plan
- **Reset and mode write:** reset_ low, then write 8'b00_11_011_0 to addr 11 → after 1 cycle CWR0 = 6'b110110, cw_load = 3'b001 for one cycle; other CWRs remain 0.
- **Mode normalisation:** write 8'b10_01_111_1 → CWR2 = 6'b010111 (mode 7 mapped to 3), cw_load = 3'b100.
- **Counter latch:** write 8'b01_00_0000 → readback1 = 2'b01 and holds for 5 idle cycles; pulse rb_ack = 3'b010 → readback1 = 2'b11 next cycle.
- **Read-back, multiple counters:** write 8'b11_0_0_101_0 → readback0 = readback2 = 2'b00, readback1 = 2'b11. Then write 8'b11_1_0_001_0 → readback0 unchanged at 00. Reserved 8'b11_0_0_111_1 → no change.
- **Ack collision:** rb_ack[0] in the same cycle as read-back 8'b11_1_0_001_0 → readback0 = 2'b10.
- **Read mux:** cnt_dout1 = 8'd119, read addr 01 → dout = 8'd119 and cs = 3'b010 after 1 cycle. Read addr 11 → dout = 8'h00. Assert reset_ mid-pending → all readback = 2'b11 immediately.
